pulse_mult: RTL

Strobe-driven pulse multiplier: each accepted one-cycle request on `in` produces a burst of N single-cycle pulses on `out`, separated by GAP idle cycles. It is the expanding counterpart of the divide-by-3 pulse FSM. It sits on the same enable/strobe path and regenerates N strobes from one decimated strobe. Requests arriving while a burst is in progress are dropped and flagged.

---
 rtl/pulse_mult.sv | 108 ++++++++++
 1 files changed

// File: rtl/pulse_mult.sv
// pulse_mult: strobe-driven pulse multiplier. Each accepted request on `in`
// becomes a burst of N one-cycle pulses on `out`, separated by GAP idle
// cycles. Requests that arrive while a burst is running are dropped and
// recorded in the sticky `overrun` flag.
package pulse_mult_pkg;
  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_PULSE = 2'b01,
    S_GAP   = 2'b10,
    S_BAD   = 2'b11
  } state_t;
endpackage

module pulse_mult
  import pulse_mult_pkg::*;
#(
  parameter int N   = 3,
  parameter int GAP = 1,
  parameter int CW  = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in,
  output logic          ready,
  output logic          out,
  output logic [1:0]    state,
  output logic [CW-1:0] remaining,
  output logic          overrun
);

  // Reload values. The gap reload is only used when GAP > 0, so a GAP of 0
  // is clamped here rather than wrapping to all ones.
  localparam logic [CW-1:0] L_NM1 = CW'(N - 1);
  localparam logic [CW-1:0] L_GM1 = (GAP > 0) ? CW'(GAP - 1) : '0;

  state_t        r_state;
  logic          r_out;
  logic [CW-1:0] r_rem;
  logic [CW-1:0] r_gap;
  logic          r_ovr;

  // Decrement helpers; the counters saturate at zero rather than wrap.
  logic [CW-1:0] w_rem_dec;
  logic [CW-1:0] w_gap_dec;
  assign w_rem_dec = (r_rem != '0) ? r_rem - 1'b1 : r_rem;
  assign w_gap_dec = (r_gap != '0) ? r_gap - 1'b1 : r_gap;

  // Burst FSM with registered pulse output, counters and sticky drop flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_out   <= 1'b0;
      r_rem   <= '0;
      r_gap   <= '0;
      r_ovr   <= 1'b0;
    end else begin
      // Any request outside IDLE is lost, including on the last pulse.
      if (in && (r_state != S_IDLE)) r_ovr <= 1'b1;

      case (r_state)
        S_IDLE: begin
          if (in) begin
            r_state <= S_PULSE;
            r_out   <= 1'b1;
            r_rem   <= L_NM1;
          end else begin
            r_out   <= 1'b0;
          end
        end
        S_PULSE: begin
          if (r_rem == '0) begin
            r_state <= S_IDLE;
            r_out   <= 1'b0;
          end else if (GAP == 0) begin
            r_out   <= 1'b1;
            r_rem   <= w_rem_dec;
          end else begin
            r_state <= S_GAP;
            r_out   <= 1'b0;
            r_gap   <= L_GM1;
          end
        end
        S_GAP: begin
          if (r_gap == '0) begin
            r_state <= S_PULSE;
            r_out   <= 1'b1;
            r_rem   <= w_rem_dec;
          end else begin
            r_gap   <= w_gap_dec;
          end
        end
        default: begin
          // Unreachable encoding: recover to a quiet IDLE.
          r_state <= S_IDLE;
          r_out   <= 1'b0;
          r_rem   <= '0;
        end
      endcase
    end
  end

  assign ready     = (r_state == S_IDLE);
  assign out       = r_out;
  assign state     = r_state;
  assign remaining = r_rem;
  assign overrun   = r_ovr;

endmodule
